// File: rtl/instr_mem.sv
// Instruction memory with a fixed-latency read pipeline feeding an in-order response FIFO.
// Optional IMEM_FAULT_EN adds rsp_fault for pointers outside the memory range.
module instr_mem #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  _reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           pointer,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           instr_out,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [31:0]           wr_data
`ifdef IMEM_FAULT_EN
  ,
  output logic                  rsp_fault
`endif
);

  localparam int FDEPTH = LATENCY + 2;
  localparam int PW     = $clog2(FDEPTH);
  localparam int CW     = $clog2(FDEPTH + 1);

  typedef struct packed {
`ifdef IMEM_FAULT_EN
    logic        flt;
`endif
    logic [31:0] data;
  } ent_t;

  logic [31:0] mem [2**DEPTH_LOG2];

  logic [LATENCY:1]       vld_pipe_q, vld_pipe_d;
  ent_t [LATENCY:1]       dat_pipe_q, dat_pipe_d;
  ent_t [FDEPTH-1:0]      fifo_q, fifo_d;
  logic [PW-1:0]          rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]          cnt_q, cnt_d, out_q, out_d;
  logic                   ready_q, ready_d;

  logic accept, pop, push, fifo_pop, fifo_empty;
  ent_t head, rd_ent;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(FDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_ent      = '0;
    rd_ent.data = mem[pointer[DEPTH_LOG2-1:0]];
`ifdef IMEM_FAULT_EN
    rd_ent.flt  = |pointer[31:DEPTH_LOG2];
    if (rd_ent.flt) rd_ent.data = '0;
`endif
  end

`ifndef IMEM_FAULT_EN
  // Upper pointer bits are ignored so addresses wrap.
  logic unused_ptr;
  assign unused_ptr = ^pointer[31:DEPTH_LOG2];
`endif

  assign accept     = req_valid && ready_q;
  assign fifo_empty = (cnt_q == '0);
  assign rsp_valid  = !fifo_empty || vld_pipe_q[LATENCY];
  // The pipeline tail bypasses an empty FIFO so an unstalled read takes exactly LATENCY cycles.
  assign head       = fifo_empty ? dat_pipe_q[LATENCY] : fifo_q[rd_q];
  assign pop        = rsp_valid && rsp_ready;
  assign push       = vld_pipe_q[LATENCY] && !(fifo_empty && rsp_ready);
  assign fifo_pop   = !fifo_empty && rsp_ready;

  assign req_ready  = ready_q;
  assign instr_out  = rsp_valid ? head.data : 32'h0;
`ifdef IMEM_FAULT_EN
  assign rsp_fault  = rsp_valid && head.flt;
`endif

  always_comb begin
    vld_pipe_d    = vld_pipe_q;
    dat_pipe_d    = dat_pipe_q;
    vld_pipe_d[1] = accept;
    dat_pipe_d[1] = rd_ent;
    for (int i = 2; i <= LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      dat_pipe_d[i] = dat_pipe_q[i-1];
    end

    fifo_d = fifo_q;
    if (push) fifo_d[wr_q] = dat_pipe_q[LATENCY];
    wr_d  = push ? inc(wr_q) : wr_q;
    rd_d  = fifo_pop ? inc(rd_q) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(fifo_pop);

    // Outstanding caps at FIFO depth, so every in-flight read has a FIFO slot waiting.
    out_d   = out_q + CW'(accept) - CW'(pop);
    ready_d = (out_d < CW'(FDEPTH));
  end

  always_ff @(posedge clk) begin
    if (_reset) begin
      vld_pipe_q <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      out_q      <= '0;
      ready_q    <= 1'b0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      ready_q    <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    dat_pipe_q <= dat_pipe_d;
    fifo_q     <= fifo_d;
  end

  // Memory is never reset and keeps accepting writes during reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_instr_mem.sv
// Directed bench for instr_mem at DEPTH_LOG2=4, LATENCY=2.
module tb_instr_mem;

  logic        clk = 1'b0;
  logic        _reset;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, wr_en;
  logic [31:0] pointer, instr_out, wr_data;
  logic [3:0]  wr_addr;
`ifdef IMEM_FAULT_EN
  logic        rsp_fault;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  instr_mem #(.DEPTH_LOG2(4), .LATENCY(2)) dut (
    .clk(clk), ._reset(_reset),
    .req_valid(req_valid), .req_ready(req_ready), .pointer(pointer),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .instr_out(instr_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
`ifdef IMEM_FAULT_EN
    , .rsp_fault(rsp_fault)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    int nrsp, first_c, last_c, acc;
    _reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; pointer = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset state, plus a write issued during reset
    step();
    wr(4'd5, 32'hDEADBEEF);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_instr_out", instr_out, 32'h0);
    _reset = 1'b0;
    step();
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);

    // Single fetch: response exactly two cycles after acceptance
    req_valid = 1'b1; pointer = 32'd5; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("lat_not_early", {31'b0, rsp_valid}, 32'd0);
    step();
    chk("lat_valid", {31'b0, rsp_valid}, 32'd1);
    chk("lat_data", instr_out, 32'hDEADBEEF);
    step();
    chk("lat_single", {31'b0, rsp_valid}, 32'd0);

    // Back-to-back fetches 0..7
    for (int i = 0; i < 8; i++) wr(4'(i), 32'h100 + 32'(i));
    nrsp = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 30 && nrsp < 8; c++) begin
      if (c < 8) begin
        req_valid = 1'b1; pointer = 32'(c);
        chk("b2b_ready", {31'b0, req_ready}, 32'd1);
      end else begin
        req_valid = 1'b0;
      end
      step();
      if (rsp_valid) begin
        chk("b2b_data", instr_out, 32'h100 + 32'(nrsp));
        if (first_c < 0) first_c = c;
        last_c = c;
        nrsp++;
      end
    end
    req_valid = 1'b0;
    chk("b2b_count", 32'(nrsp), 32'd8);
    chk("b2b_span", 32'(last_c - first_c), 32'd7);
    chk("b2b_first_lat", 32'(first_c), 32'd1);

    // Backpressure: exactly four accepted
    step();
    rsp_ready = 1'b0; acc = 0;
    for (int k = 0; k < 6; k++) begin
      req_valid = 1'b1; pointer = 32'(k);
      if (req_ready) acc++;
      step();
    end
    req_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd4);
    chk("bp_ready_low", {31'b0, req_ready}, 32'd0);
    chk("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
    chk("bp_hold_data", instr_out, 32'h100);
    rsp_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("bp_drain_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_drain_data", instr_out, 32'h100 + 32'(j));
      step();
    end
    chk("bp_empty", {31'b0, rsp_valid}, 32'd0);
    chk("bp_ready_back", {31'b0, req_ready}, 32'd1);

    // Read-before-write on the same word
    wr(4'd3, 32'hAAAA0000);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h5555FFFF;
    req_valid = 1'b1; pointer = 32'd3;
    step();
    wr_en = 1'b0; req_valid = 1'b0;
    step();
    chk("rbw_old", instr_out, 32'hAAAA0000);
    req_valid = 1'b1; pointer = 32'd3;
    step();
    req_valid = 1'b0;
    step();
    chk("rbw_new", instr_out, 32'h5555FFFF);
    step();

    // Reset with three reads outstanding
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid = 1'b1; pointer = 32'(k);
      step();
    end
    req_valid = 1'b0;
    _reset = 1'b1;
    step();
    chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_ready", {31'b0, req_ready}, 32'd0);
    chk("mid_rst_data", instr_out, 32'h0);
    _reset = 1'b0;
    step();
    chk("mid_rst_ready_back", {31'b0, req_ready}, 32'd1);
    rsp_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) acc++;
      step();
    end
    chk("mid_rst_no_stale", 32'(acc), 32'd0);

    // Out-of-range pointer
    wr(4'd3, 32'h12345678);
    req_valid = 1'b1; pointer = 32'h13;
    step();
    req_valid = 1'b0;
    step();
    chk("oor_valid", {31'b0, rsp_valid}, 32'd1);
`ifdef IMEM_FAULT_EN
    chk("oor_data", instr_out, 32'h0);
    chk("oor_fault", {31'b0, rsp_fault}, 32'd1);
    step();
    req_valid = 1'b1; pointer = 32'h3;
    step();
    req_valid = 1'b0;
    step();
    chk("inr_data", instr_out, 32'h12345678);
    chk("inr_fault", {31'b0, rsp_fault}, 32'd0);
`else
    chk("oor_wrap_data", instr_out, 32'h12345678);
`endif
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
